// File: rtl/pixel_plot_buffer_if.sv
// Plot-request / framebuffer handshake bundle for pixel_plot_buffer.
// DEPTH must match the DEPTH of the buffer instance it connects to.
interface pixel_plot_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]    in_x;
  logic [6:0]    in_y;
  logic [2:0]    in_colour;
  logic          in_plot;
  logic          clear_status;
  logic [7:0]    fb_x;
  logic [6:0]    fb_y;
  logic [2:0]    fb_colour;
  logic          fb_plot;
  logic          fb_ready;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          overflow;
  logic [15:0]   drop_count;

  modport master (
    output in_x, in_y, in_colour, in_plot, clear_status, fb_ready,
    input  fb_x, fb_y, fb_colour, fb_plot, level, empty, full, overflow, drop_count
  );

  modport slave (
    input  in_x, in_y, in_colour, in_plot, clear_status, fb_ready,
    output fb_x, fb_y, fb_colour, fb_plot, level, empty, full, overflow, drop_count
  );
endinterface

// File: rtl/pixel_plot_buffer.sv
// Clipping elastic FIFO between drawing engines and the framebuffer adapter.
// Optional macro PLOT_DEDUP_EN suppresses repeats of the last accepted pixel.
module pixel_plot_buffer #(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic              clk,
  input logic              rst,
  pixel_plot_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [8:0]    SCREEN_W_C = 9'(SCREEN_W);
  localparam logic [7:0]    SCREEN_H_C = 8'(SCREEN_H);
  localparam logic [LW-1:0] DEPTH_M1_C = LW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [17:0]     mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic            overflow_r;
  logic [15:0]     drop_count_r;

  logic [17:0]     pix_s, head_s;
  logic            on_screen_s, dup_s, eligible_s;
  logic            empty_s, full_s, pop_s, push_s, drop_s;

  assign pix_s       = {bus.in_x, bus.in_y, bus.in_colour};
  assign head_s      = mem_r[rd_ptr_r];
  assign on_screen_s = ({1'b0, bus.in_x} < SCREEN_W_C) && ({1'b0, bus.in_y} < SCREEN_H_C);
  assign eligible_s  = bus.in_plot && on_screen_s && !dup_s;
  assign empty_s     = (state_r == ST_EMPTY);
  assign full_s      = (state_r == ST_FULL);
  assign pop_s       = !empty_s && bus.fb_ready;
  // A full FIFO can still take a pixel when the head leaves in the same cycle
  assign push_s      = eligible_s && (!full_s || pop_s);
  assign drop_s      = eligible_s && full_s && !pop_s;

`ifdef PLOT_DEDUP_EN
  logic [17:0] last_pix_r;
  logic        last_vld_r;

  // Remember the last accepted pixel so immediate repeats are discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pix_r <= 18'd0;
      last_vld_r <= 1'b0;
    end else if (bus.clear_status) begin
      last_vld_r <= 1'b0;
    end else if (push_s) begin
      last_pix_r <= pix_s;
      last_vld_r <= 1'b1;
    end
  end

  assign dup_s = last_vld_r && (last_pix_r == pix_s);
`else
  assign dup_s = 1'b0;
`endif

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Occupancy state transitions
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (push_s) state_nxt_s = ST_ACTIVE;
        else        state_nxt_s = ST_EMPTY;
      end
      ST_ACTIVE: begin
        if (push_s && !pop_s && level_r == DEPTH_M1_C)     state_nxt_s = ST_FULL;
        else if (pop_s && !push_s && level_r == LW'(1))    state_nxt_s = ST_EMPTY;
        else                                               state_nxt_s = ST_ACTIVE;
      end
      ST_FULL: begin
        if (pop_s && !push_s) state_nxt_s = ST_ACTIVE;
        else                  state_nxt_s = ST_FULL;
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Storage, pointers and occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 18'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= pix_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; clear beats a same-cycle drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 16'd0;
    end else if (bus.clear_status) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 16'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_count_r != 16'hFFFF) drop_count_r <= drop_count_r + 16'd1;
    end
  end

  assign bus.fb_x       = head_s[17:10];
  assign bus.fb_y       = head_s[9:3];
  assign bus.fb_colour  = head_s[2:0];
  assign bus.fb_plot    = !empty_s;
  assign bus.level      = level_r;
  assign bus.empty      = empty_s;
  assign bus.full       = full_s;
  assign bus.overflow   = overflow_r;
  assign bus.drop_count = drop_count_r;
endmodule

// File: tb/tb_pixel_plot_buffer.sv
// Self-checking bench for pixel_plot_buffer: directed tables, corner sequences
// and random traffic against a queue-based reference model.
module tb_pixel_plot_buffer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_plot_buffer_if #(.DEPTH(DEPTH)) bus ();

  pixel_plot_buffer #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [17:0] mq[$];
  logic        m_ovf;
  int          m_dc;
  logic [17:0] m_last;
  logic        m_last_vld;
  logic [17:0] dut_out[$];

  typedef struct {
    int x;
    int y;
    int c;
    bit exp_plot;
  } clip_vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf      = 1'b0;
    m_dc       = 0;
    m_last     = 18'd0;
    m_last_vld = 1'b0;
  endtask

  task automatic model_step(input int x, input int y, input int c,
                            input bit plot, input bit ready, input bit clr);
    logic [17:0] pix;
    bit pop, dup, elig, acc;
    pix = {8'(x), 7'(y), 3'(c)};
    pop = (mq.size() > 0) && ready;
    dup = 1'b0;
`ifdef PLOT_DEDUP_EN
    dup = m_last_vld && (m_last == pix);
`endif
    elig = plot && (x < 160) && (y < 120) && !dup;
    acc  = 1'b0;
    if (pop) void'(mq.pop_front());
    if (elig) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(pix);
        acc = 1'b1;
      end else begin
        m_ovf = 1'b1;
        if (m_dc < 65535) m_dc++;
      end
    end
    if (clr) begin
      m_ovf      = 1'b0;
      m_dc       = 0;
      m_last_vld = 1'b0;
    end else if (acc) begin
      m_last     = pix;
      m_last_vld = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("fb_plot", bus.fb_plot, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("fb_x", bus.fb_x, mq[0][17:10]);
      chk("fb_y", bus.fb_y, mq[0][9:3]);
      chk("fb_colour", bus.fb_colour, mq[0][2:0]);
    end
    chk("level", bus.level, mq.size());
    chk("empty", bus.empty, mq.size() == 0);
    chk("full", bus.full, mq.size() == DEPTH);
    chk("overflow", bus.overflow, m_ovf);
    chk("drop_count", bus.drop_count, m_dc);
  endtask

  // One clock: called and returning on a falling edge
  task automatic cycle(input int x, input int y, input int c,
                       input bit plot, input bit ready, input bit clr);
    bus.in_x         = 8'(x);
    bus.in_y         = 7'(y);
    bus.in_colour    = 3'(c);
    bus.in_plot      = plot;
    bus.fb_ready     = ready;
    bus.clear_status = clr;
    if (bus.fb_plot && ready) dut_out.push_back({bus.fb_x, bus.fb_y, bus.fb_colour});
    @(posedge clk);
    model_step(x, y, c, plot, ready, clr);
    @(negedge clk);
    check_model();
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) cycle(0, 0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset();
    chk("rst_fb_x", bus.fb_x, 0);
    chk("rst_fb_y", bus.fb_y, 0);
    chk("rst_fb_colour", bus.fb_colour, 0);
    chk("rst_fb_plot", bus.fb_plot, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_drop_count", bus.drop_count, 0);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.in_plot      = 1'b0;
    bus.fb_ready     = 1'b0;
    bus.clear_status = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk_reset();
  endtask

  clip_vec_t tv[8];

  initial begin
    tv[0] = '{159, 119, 7, 1'b1};
    tv[1] = '{160,   0, 1, 1'b0};
    tv[2] = '{  0, 120, 1, 1'b0};
    tv[3] = '{200,  50, 2, 1'b0};
    tv[4] = '{  0,   0, 5, 1'b1};
    tv[5] = '{159,   0, 0, 1'b1};
    tv[6] = '{  0, 119, 6, 1'b1};
    tv[7] = '{255, 127, 7, 1'b0};

    rst          = 1'b1;
    bus.in_x     = 8'd0;
    bus.in_y     = 7'd0;
    bus.in_colour = 3'd0;
    bus.in_plot  = 1'b0;
    bus.fb_ready = 1'b0;
    bus.clear_status = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset();

    // Reset in the middle of a draw discards the queue
    for (int i = 0; i < 5; i++) cycle(i + 1, i + 2, 1, 1'b1, 1'b0, 1'b0);
    chk("mid_level", bus.level, 5);
    do_reset();
    cycle(10, 20, 3, 1'b1, 1'b0, 1'b0);
    chk("post_rst_plot", bus.fb_plot, 1);
    chk("post_rst_x", bus.fb_x, 10);
    chk("post_rst_y", bus.fb_y, 20);
    chk("post_rst_c", bus.fb_colour, 3);
    drain();

    // Clipping table
    for (int i = 0; i < 8; i++) begin
      cycle(tv[i].x, tv[i].y, tv[i].c, 1'b1, 1'b1, 1'b0);
      chk("clip_plot", bus.fb_plot, tv[i].exp_plot);
      if (tv[i].exp_plot) begin
        chk("clip_x", bus.fb_x, tv[i].x);
        chk("clip_y", bus.fb_y, tv[i].y);
        chk("clip_c", bus.fb_colour, tv[i].c);
      end
      cycle(0, 0, 0, 1'b0, 1'b1, 1'b0);
    end
    chk("clip_ovf", bus.overflow, 0);
    chk("clip_dc", bus.drop_count, 0);

    // Order and back-pressure
    dut_out.delete();
    for (int i = 0; i < 16; i++) cycle(i, 5, 2, 1'b1, 1'b0, 1'b0);
    chk("ord_full", bus.full, 1);
    chk("ord_level", bus.level, 16);
    drain();
    chk("ord_count", dut_out.size(), 16);
    for (int i = 0; i < 16 && i < dut_out.size(); i++)
      chk("ord_pix", dut_out[i], {8'(i), 7'd5, 3'd2});
    chk("ord_empty", bus.empty, 1);

    // Overflow then clear
    dut_out.delete();
    for (int i = 0; i < 20; i++) cycle(i + 40, 7, 4, 1'b1, 1'b0, 1'b0);
    chk("ovf_level", bus.level, 16);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_dc", bus.drop_count, 4);
    cycle(0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("clr_flag", bus.overflow, 0);
    chk("clr_dc", bus.drop_count, 0);
    chk("clr_level", bus.level, 16);
    drain();
    chk("ovf_count", dut_out.size(), 16);
    for (int i = 0; i < 16 && i < dut_out.size(); i++)
      chk("ovf_pix", dut_out[i], {8'(i + 40), 7'd7, 3'd4});

    // Full with simultaneous pop
    dut_out.delete();
    for (int i = 0; i < 16; i++) cycle(100 + i, 9, 6, 1'b1, 1'b0, 1'b0);
    cycle(1, 1, 1, 1'b1, 1'b1, 1'b0);
    chk("fp_level", bus.level, 16);
    chk("fp_dc", bus.drop_count, 0);
    chk("fp_ovf", bus.overflow, 0);
    drain();
    chk("fp_count", dut_out.size(), 17);
    if (dut_out.size() == 17) chk("fp_last", dut_out[16], {8'd1, 7'd1, 3'd1});

    // Duplicate suppression
    cycle(0, 0, 0, 1'b0, 1'b0, 1'b1);
    dut_out.delete();
    for (int i = 0; i < 3; i++) cycle(30, 40, 4, 1'b1, 1'b0, 1'b0);
    cycle(30, 40, 5, 1'b1, 1'b0, 1'b0);
    drain();
`ifdef PLOT_DEDUP_EN
    chk("dedup_count", dut_out.size(), 2);
`else
    chk("dedup_count", dut_out.size(), 4);
`endif

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      int x, y, c;
      bit plot, ready, clr;
      if ($urandom_range(0, 1) == 0) begin
        x = int'($urandom_range(157, 162));
        y = int'($urandom_range(117, 122));
        c = int'($urandom_range(0, 1));
      end else begin
        x = int'($urandom_range(0, 255));
        y = int'($urandom_range(0, 127));
        c = int'($urandom_range(0, 7));
      end
      plot  = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      cycle(x, y, c, plot, ready, clr);
      if (n == 500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_plot_buffer.md
Name: pixel_plot_buffer

Overview:
Elastic pixel buffer between the drawing engines (fillscreen, circle, reuleaux) and the VGA framebuffer adapter. The engines emit one plot request per cycle and have no back-pressure. This block clips off-screen pixels, queues on-screen ones in a FIFO, and replays them to the adapter under a valid/ready handshake. It also reports the drop/overflow status that the top-level controller reads after each draw's done.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
SCREEN_W, 160, pixel x at or above this value is clipped
SCREEN_H, 120, pixel y at or above this value is clipped

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_x  in  8  pixel x from drawing engine
in_y  in  7  pixel y from drawing engine
in_colour  in  3  pixel colour
in_plot  in  1  plot request, sampled every cycle
clear_status  in  1  synchronous clear of overflow and drop_count
fb_x  out  8  head-of-queue x
fb_y  out  7  head-of-queue y
fb_colour  out  3  head-of-queue colour
fb_plot  out  1  head valid (queue not empty)
fb_ready  in  1  adapter accepts head this cycle
level  out  $clog2(DEPTH)+1  current occupancy
empty  out  1  level == 0
full  out  1  level == DEPTH
overflow  out  1  sticky: an on-screen pixel was lost because the FIFO was full
drop_count  out  16  saturating count of pixels lost to overflow

Behaviour:
- Reset (async assert, sync release): all outputs are 0 (fb_* = 0, fb_plot = 0, level = 0, empty = 1, full = 0, overflow = 0, drop_count = 0). Pointers are 0. Queued contents are discarded, including a reset in the middle of a draw.
- Clip: a push is eligible only when in_plot = 1 and in_x < SCREEN_W and in_y < SCREEN_H. A clipped pixel is silently discarded. It is not counted and does not set overflow.
- Pop: occurs when fb_plot = 1 and fb_ready = 1.
- fb_x, fb_y and fb_colour always reflect mem[rd_ptr] (first-word fall-through). fb_plot = !empty.
- Latency: a pixel pushed into an empty FIFO at edge N is presented on fb_* with fb_plot = 1 after edge N. Minimum pass-through is one cycle. There is no combinational path from in_* to fb_*.
- Push when not full: written at wr_ptr, wr_ptr increments.
- Push when full:
  - With a pop in the same cycle: the push is accepted and level stays at DEPTH.
  - Without a pop: the pixel is dropped, overflow is set to 1, and drop_count increments, saturating at 16'hFFFF.
- Simultaneous push and pop when not full or empty: level unchanged, both pointers advance.
- Pop when empty: impossible, since fb_plot = 0. fb_ready is ignored.
- Pointers wrap modulo DEPTH. level is tracked by an explicit counter, or by pointers carrying one extra wrap bit.
- clear_status = 1 clears overflow and drop_count at the next edge. If a drop happens in the same cycle, clear wins: overflow = 0, drop_count = 0.
- Control FSM, states:
  - EMPTY: level 0
  - ACTIVE: 0 < level < DEPTH
  - FULL: level == DEPTH
  - Transitions follow the occupancy rules above. empty and full decode from state/level, not from a separate register.
- in_colour is stored unmodified. Colour is never used for clipping.

Optional Feature:
Macro PLOT_DEDUP_EN.
- Defined: the block holds a last-accepted pixel register (x, y, colour, valid). An eligible push identical in x, y and colour to the last accepted pixel is discarded without touching the FIFO, overflow or drop_count. The register is valid-cleared by reset and by clear_status. This removes the duplicate axis and octant pixels produced by the circle engines.
- Not defined: the register and comparator are absent, and every eligible pixel is pushed.

Test Plan:
- Reset mid-draw: push 5 pixels with fb_ready = 0, assert rst for 1 cycle -> fb_plot = 0, level = 0, empty = 1. A subsequent push of (10,20,3) appears on fb_* one cycle later.
- Clipping: push (159,119,7), (160,0,1), (0,120,1), (200,50,2) with fb_ready = 1 -> only (159,119,7) emitted, overflow = 0, drop_count = 0.
- Order and back-pressure: push x = 0..15 (y = 5, colour = 2) with fb_ready = 0 -> full = 1, level = 16. Then raise fb_ready -> x = 0..15 delivered in order, one per cycle, then empty = 1.
- Overflow: fb_ready = 0, push 20 distinct pixels -> level = 16, overflow = 1, drop_count = 4. Then clear_status -> overflow = 0, drop_count = 0, and the 16 queued pixels are intact.
- Full with simultaneous pop: fill to 16, then push (1,1,1) with fb_ready = 1 in the same cycle -> no drop, level = 16, (1,1,1) delivered last.
- PLOT_DEDUP_EN: push (30,40,4) three times consecutively, then (30,40,5) -> with macro, 2 pixels emitted; without macro, 4 pixels emitted.
